prog_clock_divider: RTL and testbench

Multi-channel, runtime-programmable clock-enable generator for the jackpot game datapath. Replaces the fixed single-divisor divider. Each channel derives a square wave and a single-cycle tick from the board clock, with an independently loadable divisor and enable. Reels, blink logic and the debounce sampler consume the ticks; the square waves drive LEDs only, never as clocks.

---
 rtl/prog_clock_divider.sv | 122 ++++++++++++
 tb/tb_prog_clock_divider.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock-enable generator: per-channel
// square wave and one-cycle tick, each with a loadable divisor.
//
// Ports:
//   clkIN        system clock, rising edge
//   rst          asynchronous active-high reset
//   en           per-channel count enable
//   load         one-cycle divisor load strobe
//   load_ch      target channel of the load
//   load_div     new divisor (values below 2 clamp to 2)
//   load_restart with load: restart the target channel now
//   clkOUT       per-channel registered square wave
//   tick         per-channel one-cycle pulse per period
//   load_err     one-cycle pulse on a rejected or clamped load
module prog_clock_divider #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 27,
  parameter int DEFAULT_DIV = 125_000_000,
  localparam int CH_W =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clkIN,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                load,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [WIDTH-1:0]    load_div,
  input  logic                load_restart,
  output logic [CHANNELS-1:0] clkOUT,
  output logic [CHANNELS-1:0] tick,
  output logic                load_err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
  // A misconfigured default below 2 runs as 2.
  localparam logic [WIDTH-1:0] DEF_DIV =
    (DEFAULT_DIV < 2) ? MIN_DIV : WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt_q [CHANNELS];
  logic [WIDTH-1:0] cnt_d [CHANNELS];
  logic [WIDTH-1:0] div_act_q [CHANNELS];
  logic [WIDTH-1:0] div_act_d [CHANNELS];
  logic [WIDTH-1:0] div_pend_q [CHANNELS];
  logic [WIDTH-1:0] div_pend_d [CHANNELS];
  logic [CHANNELS-1:0] clk_q, clk_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] wrap, sel;
  logic load_err_q, load_err_d;
  logic ch_ok, div_low;
  logic [WIDTH-1:0] ld_val;

  always_comb begin
    ch_ok   = 32'(load_ch) < 32'(CHANNELS);
    div_low = load_div < MIN_DIV;
    ld_val  = div_low ? MIN_DIV : load_div;
    load_err_d = load & (~ch_ok | div_low);
    wrap = '0;
    sel  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]      = cnt_q[i];
      div_act_d[i]  = div_act_q[i];
      div_pend_d[i] = div_pend_q[i];
      clk_d[i]      = clk_q[i];
      tick_d[i]     = 1'b0;
      wrap[i] = en[i] &&
        (cnt_q[i] == div_act_q[i] - ONE);
      sel[i] = load && ch_ok &&
        (32'(load_ch) == 32'(i));
      if (wrap[i]) begin
        cnt_d[i]     = '0;
        clk_d[i]     = 1'b0;
        tick_d[i]    = 1'b1;
        div_act_d[i] = div_pend_q[i];
      end else if (en[i]) begin
        cnt_d[i] = cnt_q[i] + ONE;
        clk_d[i] = (cnt_q[i] + ONE) >=
          (div_act_q[i] >> 1);
      end
      if (sel[i]) begin
        div_pend_d[i] = ld_val;
        if (load_restart) begin
          div_act_d[i] = ld_val;
          cnt_d[i]     = '0;
          clk_d[i]     = 1'b0;
          tick_d[i]    = 1'b0;
        end else if (wrap[i]) begin
          // A load landing on the wrap edge beats
          // the older pending value.
          div_act_d[i] = ld_val;
        end
      end
    end
  end

  always_ff @(posedge clkIN or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]      <= '0;
        div_act_q[i]  <= DEF_DIV;
        div_pend_q[i] <= DEF_DIV;
      end
      clk_q      <= '0;
      tick_q     <= '0;
      load_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]      <= cnt_d[i];
        div_act_q[i]  <= div_act_d[i];
        div_pend_q[i] <= div_pend_d[i];
      end
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      load_err_q <= load_err_d;
    end
  end

  assign clkOUT   = clk_q;
  assign tick     = tick_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: expected outputs are
// queued as stimulus is driven and compared after each edge.
module tb_prog_clock_divider;

  localparam int NCH = 3;
  localparam int W   = 8;
  localparam int DEF = 4;

  logic           clkIN = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           load;
  logic [1:0]     load_ch;
  logic [W-1:0]   load_div;
  logic           load_restart;
  logic [NCH-1:0] clkOUT;
  logic [NCH-1:0] tick;
  logic           load_err;

  prog_clock_divider #(
    .CHANNELS(NCH),
    .WIDTH(W),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clkIN(clkIN),
    .rst(rst),
    .en(en),
    .load(load),
    .load_ch(load_ch),
    .load_div(load_div),
    .load_restart(load_restart),
    .clkOUT(clkOUT),
    .tick(tick),
    .load_err(load_err)
  );

  always #5 clkIN = ~clkIN;

  typedef struct {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] tck;
    logic           err;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  int m_cnt [NCH];
  int m_act [NCH];
  int m_pend [NCH];
  logic [NCH-1:0] m_clk, m_tick;
  logic m_err;

  task automatic expect_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i]  = 0;
      m_act[i]  = DEF;
      m_pend[i] = DEF;
    end
    m_clk  = '0;
    m_tick = '0;
    m_err  = 1'b0;
  endtask

  // Reference behaviour: a period of div cycles, low for the
  // first div/2 positions, tick on the wrap.
  task automatic model_step();
    int  v;
    bit  ok;
    bit  w;
    v  = (int'(load_div) < 2) ? 2 : int'(load_div);
    ok = int'(load_ch) < NCH;
    for (int i = 0; i < NCH; i++) begin
      w = 0;
      m_tick[i] = 1'b0;
      if (en[i]) begin
        if (m_cnt[i] == m_act[i] - 1) begin
          m_cnt[i]  = 0;
          m_clk[i]  = 1'b0;
          m_tick[i] = 1'b1;
          m_act[i]  = m_pend[i];
          w = 1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
          m_clk[i] = m_cnt[i] >= m_act[i] / 2;
        end
      end
      if (load && ok && int'(load_ch) == i) begin
        m_pend[i] = v;
        if (load_restart) begin
          m_act[i]  = v;
          m_cnt[i]  = 0;
          m_clk[i]  = 1'b0;
          m_tick[i] = 1'b0;
        end else if (w) begin
          m_act[i] = v;
        end
      end
    end
    m_err = load && (!ok || int'(load_div) < 2);
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    sb.push_back('{m_clk, m_tick, m_err});
    @(posedge clkIN);
    #1;
    if (sb.size() == 0) begin
      expect_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      expect_eq("clkOUT", 32'(clkOUT), 32'(e.clk));
      expect_eq("tick", 32'(tick), 32'(e.tck));
      expect_eq("load_err", 32'(load_err), 32'(e.err));
    end
  endtask

  task automatic do_load(input int ch, input int dv,
                         input logic rs);
    load         = 1'b1;
    load_ch      = 2'(ch);
    load_div     = W'(dv);
    load_restart = rs;
    cyc();
    load         = 1'b0;
    load_restart = 1'b0;
    load_div     = '0;
    load_ch      = '0;
  endtask

  initial begin
    logic [7:0] pat;
    int first;
    int t1;
    int t2;

    rst = 1'b1;
    en = '0;
    load = 1'b0;
    load_ch = '0;
    load_div = '0;
    load_restart = 1'b0;
    model_reset();
    @(posedge clkIN);
    #1;
    expect_eq("rst_clk", 32'(clkOUT), 32'd0);
    expect_eq("rst_tick", 32'(tick), 32'd0);
    expect_eq("rst_err", 32'(load_err), 32'd0);
    #2;
    rst = 1'b0;
    en = '1;

    // Default divisor 4: 0,1,1,0,0,1,1,0 after release.
    pat = '0;
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      pat = {pat[6:0], clkOUT[0]};
      if (first == 0 && tick[0]) first = k;
    end
    expect_eq("pattern_ch0", 32'(pat), 32'h66);
    expect_eq("first_tick", 32'(first), 32'd4);

    // Restart ch1 with divisor 5.
    do_load(1, 5, 1'b1);
    t1 = 0;
    t2 = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (tick[1]) begin
        if (t1 == 0) t1 = k;
        else if (t2 == 0) t2 = k;
      end
    end
    expect_eq("ch1_first", 32'(t1), 32'd5);
    expect_eq("ch1_period", 32'(t2 - t1), 32'd5);

    // Divisor 2 on ch0 mid-period, no restart.
    cyc();
    do_load(0, 2, 1'b0);
    for (int k = 0; k < 10; k++) cyc();

    // Freeze ch2 for 7 cycles.
    cyc();
    en = 3'b011;
    for (int k = 0; k < 7; k++) cyc();
    en = '1;
    for (int k = 0; k < 8; k++) cyc();

    // Bad channel, then clamped divisor.
    do_load(3, 6, 1'b1);
    cyc();
    do_load(2, 0, 1'b1);
    for (int k = 0; k < 6; k++) cyc();

    // Load wins on ch1's wrap edge without restart.
    while (m_cnt[1] != m_act[1] - 1) cyc();
    do_load(1, 3, 1'b0);
    for (int k = 0; k < 7; k++) cyc();

    // Pending load then async reset mid-period.
    do_load(1, 7, 1'b0);
    do_load(0, 3, 1'b1);
    cyc();
    expect_eq("pre_rst_clk0", 32'(clkOUT[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    expect_eq("async_clk", 32'(clkOUT), 32'd0);
    expect_eq("async_tick", 32'(tick), 32'd0);
    expect_eq("async_err", 32'(load_err), 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (first == 0 && tick == 3'b111) first = k;
    end
    expect_eq("post_rst_tick", 32'(first), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
